fir_ntap_core: RTL



---
 rtl/fir_pkg.sv | 56 +++++
 rtl/fir_if.sv | 35 +++
 rtl/fir_tap.sv | 46 ++++
 rtl/fir_ntap_core.sv | 138 +++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// ============================================================================
// Module      : fir_pkg
// Description : Shared types and width/saturation helpers for the FIR core.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fir_pkg;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } fir_state_e;

    localparam int c_SAT_W = 64;

    // Ceiling log2; a single tap needs no growth bits.
    function automatic int fir_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int fir_bw_acc(input int bw_in, input int bw_coef, input int n_taps);
        return bw_in + bw_coef + fir_clog2(n_taps);
    endfunction

    // Arithmetic shift drops the low bits (truncation), then clamps to bw_out signed range.
    function automatic logic signed [c_SAT_W-1:0] fir_sat(
        input logic signed [c_SAT_W-1:0] acc,
        input int                        shift,
        input int                        bw_out
    );
        logic signed [c_SAT_W-1:0] v;
        logic signed [c_SAT_W-1:0] hi;
        logic signed [c_SAT_W-1:0] lo;
        v  = acc >>> shift;
        hi = (64'sd1 <<< (bw_out - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw_out - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_if.sv
// ============================================================================
// Module      : fir_if
// Description : Sample/coefficient input handshake and filter output bundle.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fir_if #(
    parameter int BW_IN  = 6,
    parameter int BW_OUT = 8
);
    logic              in_valid;
    logic [BW_IN-1:0]  x_in;
    logic              coef_loaded;
    logic              y_valid;
    logic [BW_OUT-1:0] y_out;

    modport master (
        output in_valid,
        output x_in,
        input  coef_loaded,
        input  y_valid,
        input  y_out
    );

    modport slave (
        input  in_valid,
        input  x_in,
        output coef_loaded,
        output y_valid,
        output y_out
    );
endinterface

`default_nettype wire

// File: rtl/fir_tap.sv
// ============================================================================
// Module      : fir_tap
// Description : One FIR tap: coefficient register, delay register, signed multiply.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_tap #(
    parameter int BW_IN   = 6,
    parameter int BW_COEF = 6
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             coef_we_i,
    input  logic signed [BW_COEF-1:0]        coef_i,
    input  logic                             shift_en_i,
    input  logic signed [BW_IN-1:0]          sample_i,
    output logic signed [BW_IN-1:0]          sample_o,
    output logic signed [BW_IN+BW_COEF-1:0]  prod_o
);
    localparam int c_BW_PROD = BW_IN + BW_COEF;

    logic signed [BW_COEF-1:0] coef_q;
    logic signed [BW_IN-1:0]   dly_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            coef_q <= '0;
            dly_q  <= '0;
        end else begin
            if (coef_we_i) begin
                coef_q <= coef_i;
            end
            if (shift_en_i) begin
                dly_q <= sample_i;
            end
        end
    end

    // sample_i is this tap's view of the line including the sample being accepted.
    assign prod_o   = c_BW_PROD'(coef_q) * c_BW_PROD'(sample_i);
    assign sample_o = dly_q;

endmodule

`default_nettype wire

// File: rtl/fir_ntap_core.sv
// ============================================================================
// Module      : fir_ntap_core
// Description : N-tap direct-form FIR with serial coefficient load and
//               registered output. Define FIR_SAT_EN to clamp instead of wrap.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_ntap_core
    import fir_pkg::*;
#(
    parameter int N_TAPS    = 4,
    parameter int BW_IN     = 6,
    parameter int BW_COEF   = 6,
    parameter int BW_OUT    = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic  clk,
    input  logic  reset,
    fir_if.slave  bus
);
    localparam int c_BW_PROD  = BW_IN + BW_COEF;
    localparam int c_BW_ACC   = fir_bw_acc(BW_IN, BW_COEF, N_TAPS);
    localparam int c_IDX_W    = (N_TAPS > 1) ? fir_clog2(N_TAPS) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_TAPS - 1);

    if (OUT_SHIFT + BW_OUT > c_BW_ACC) begin : g_bad_slice
        $error("fir_ntap_core: OUT_SHIFT+BW_OUT exceeds accumulator width");
    end

    fir_state_e           state_q, state_d;
    logic [c_IDX_W-1:0]   idx_q, idx_d;
    logic                 coef_loaded_q, coef_loaded_d;
    logic                 y_valid_q, y_valid_d;
    logic [BW_OUT-1:0]    y_q, y_d;

    logic                          w_coef_we;
    logic                          w_shift_en;
    logic signed [BW_COEF-1:0]     w_coef_in;
    logic signed [BW_IN-1:0]       w_samp [N_TAPS+1];
    logic signed [c_BW_PROD-1:0]   w_prod [N_TAPS];
    logic signed [c_BW_ACC-1:0]    w_acc;
    logic [BW_OUT-1:0]             w_y_next;

    if (BW_COEF > BW_IN) begin : g_coef_sext
        assign w_coef_in = BW_COEF'(signed'(bus.x_in));
    end else begin : g_coef_trunc
        assign w_coef_in = bus.x_in[BW_COEF-1:0];
    end

    assign w_samp[0] = bus.x_in;

    for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
        fir_tap #(
            .BW_IN   (BW_IN),
            .BW_COEF (BW_COEF)
        ) u_tap (
            .clk        (clk),
            .reset      (reset),
            .coef_we_i  (w_coef_we && (idx_q == c_IDX_W'(k))),
            .coef_i     (w_coef_in),
            .shift_en_i (w_shift_en),
            .sample_i   (w_samp[k]),
            .sample_o   (w_samp[k+1]),
            .prod_o     (w_prod[k])
        );
    end

    // Accumulator is wide enough that the sum of all products cannot overflow.
    always_comb begin
        w_acc = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            w_acc = w_acc + c_BW_ACC'(w_prod[k]);
        end
    end

`ifdef FIR_SAT_EN
    assign w_y_next = BW_OUT'(fir_sat(c_SAT_W'(w_acc), OUT_SHIFT, BW_OUT));
`else
    assign w_y_next = w_acc[OUT_SHIFT +: BW_OUT];
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        w_coef_we  = 1'b0;
        w_shift_en = 1'b0;
        y_valid_d  = 1'b0;
        y_d        = y_q;
        case (state_q)
            ST_LOAD: begin
                if (bus.in_valid) begin
                    w_coef_we = 1'b1;
                    if (idx_q == c_IDX_LAST) begin
                        state_d = ST_RUN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.in_valid) begin
                    w_shift_en = 1'b1;
                    y_valid_d  = 1'b1;
                    y_d        = w_y_next;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        coef_loaded_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_LOAD;
            idx_q         <= '0;
            coef_loaded_q <= 1'b0;
            y_valid_q     <= 1'b0;
            y_q           <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            coef_loaded_q <= coef_loaded_d;
            y_valid_q     <= y_valid_d;
            y_q           <= y_d;
        end
    end

    assign bus.coef_loaded = coef_loaded_q;
    assign bus.y_valid     = y_valid_q;
    assign bus.y_out       = y_q;

endmodule

`default_nettype wire
